// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the dynamic branch predictor: 2-bit counter
// encodings and default table geometry.
package branch_predictor_pkg;

  // Two-bit saturating direction counter; the MSB is the taken prediction.
  typedef enum logic [1:0] {
    BP_SNT = 2'b00,  // strongly not taken
    BP_WNT = 2'b01,  // weakly not taken
    BP_WT  = 2'b10,  // weakly taken
    BP_ST  = 2'b11   // strongly taken
  } bp_ctr_e;

  localparam int BP_IDX_BITS = 6;
  localparam int BP_TAG_BITS = 8;

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Next-state function of one 2-bit saturating direction counter.
module bp_sat_counter
  import branch_predictor_pkg::*;
(
  input  bp_ctr_e    ctr_cur,
  input  logic       taken,
  output bp_ctr_e    ctr_next
);

  // Step toward taken/not-taken, clamping at both ends.
  always_comb begin
    ctr_next = ctr_cur;
    unique case (ctr_cur)
      BP_SNT:  ctr_next = taken ? BP_WNT : BP_SNT;
      BP_WNT:  ctr_next = taken ? BP_WT  : BP_SNT;
      BP_WT:   ctr_next = taken ? BP_ST  : BP_WNT;
      BP_ST:   ctr_next = taken ? BP_ST  : BP_WT;
      default: ctr_next = ctr_cur;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped, tagged branch predictor: combinational lookup at fetch,
// training and misprediction detection at execute.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int IDX_BITS = BP_IDX_BITS,
  parameter int TAG_BITS = BP_TAG_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [31:0] br_count,
  output logic [31:0] mp_count
);

  localparam int ENTRIES = 1 << IDX_BITS;

  logic [ENTRIES-1:0]  valid_q, valid_d;
  logic [TAG_BITS-1:0] tag_q [ENTRIES];
  logic [TAG_BITS-1:0] tag_d [ENTRIES];
  bp_ctr_e             ctr_q [ENTRIES];
  bp_ctr_e             ctr_d [ENTRIES];
  logic [31:0]         tgt_q [ENTRIES];
  logic [31:0]         tgt_d [ENTRIES];

  logic        mispredict_q, mispredict_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [31:0] br_count_q, br_count_d;
  logic [31:0] mp_count_q, mp_count_d;

  logic [IDX_BITS-1:0] if_idx, ex_idx;
  logic [TAG_BITS-1:0] if_tag, ex_tag;
  logic                if_hit, ex_hit, upd, mp;
  bp_ctr_e             ctr_upd;

  assign if_idx = if_pc[IDX_BITS+1:2];
  assign if_tag = if_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
  assign ex_idx = ex_pc[IDX_BITS+1:2];
  assign ex_tag = ex_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];

  // Lookup reads the registered table only, so a same-cycle update is not
  // forwarded; the fetch side sees it one cycle later.
  assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign pred_taken  = if_hit && ctr_q[if_idx][1];
  assign pred_target = pred_taken ? tgt_q[if_idx] : if_pc + 32'd4;

  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign upd    = ex_valid && ex_is_branch;
  assign mp     = upd && ((ex_taken != ex_pred_taken) ||
                          (ex_taken && (ex_pred_target != ex_target)));

  bp_sat_counter u_sat_counter (
    .ctr_cur  (ctr_q[ex_idx]),
    .taken    (ex_taken),
    .ctr_next (ctr_upd)
  );

  // Table training, redirect generation and saturating statistics.
  always_comb begin
    valid_d       = valid_q;
    tag_d         = tag_q;
    ctr_d         = ctr_q;
    tgt_d         = tgt_q;
    mispredict_d  = mp;
    redirect_pc_d = redirect_pc_q;
    br_count_d    = br_count_q;
    mp_count_d    = mp_count_q;

    if (upd) begin
      if (ex_hit) begin
        ctr_d[ex_idx] = ctr_upd;
        if (ex_taken) tgt_d[ex_idx] = ex_target;
      end else begin
        // Miss or alias: the resolving branch takes over the entry.
        valid_d[ex_idx] = 1'b1;
        tag_d[ex_idx]   = ex_tag;
        ctr_d[ex_idx]   = ex_taken ? BP_WT : BP_WNT;
        tgt_d[ex_idx]   = ex_target;
      end
      if (br_count_q != 32'hFFFF_FFFF) br_count_d = br_count_q + 32'd1;
    end

    if (mp) begin
      redirect_pc_d = ex_taken ? ex_target : ex_pc + 32'd4;
      if (mp_count_q != 32'hFFFF_FFFF) mp_count_d = mp_count_q + 32'd1;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '0;
        ctr_q[i] <= BP_WNT;
        tgt_q[i] <= '0;
      end
      mispredict_q  <= 1'b0;
      redirect_pc_q <= '0;
      br_count_q    <= '0;
      mp_count_q    <= '0;
    end else begin
      valid_q       <= valid_d;
      tag_q         <= tag_d;
      ctr_q         <= ctr_d;
      tgt_q         <= tgt_d;
      mispredict_q  <= mispredict_d;
      redirect_pc_q <= redirect_pc_d;
      br_count_q    <= br_count_d;
      mp_count_q    <= mp_count_d;
    end
  end

  assign mispredict  = mispredict_q;
  assign redirect_pc = redirect_pc_q;
  assign br_count    = br_count_q;
  assign mp_count    = mp_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed vector table, reset-in-flight
// sequence, then random traffic against a behavioural model.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] if_pc = '0;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid = 1'b0;
  logic        ex_is_branch = 1'b0;
  logic [31:0] ex_pc = '0;
  logic        ex_taken = 1'b0;
  logic [31:0] ex_target = '0;
  logic        ex_pred_taken = 1'b0;
  logic [31:0] ex_pred_target = '0;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] br_count;
  logic [31:0] mp_count;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk            (clk),
    .rst            (rst),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .ex_valid       (ex_valid),
    .ex_is_branch   (ex_is_branch),
    .ex_pc          (ex_pc),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .mispredict     (mispredict),
    .redirect_pc    (redirect_pc),
    .br_count       (br_count),
    .mp_count       (mp_count)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_valid [64];
  logic [7:0]  m_tag   [64];
  int          m_ctr   [64];  // 0..3, >=2 means predict taken
  logic [31:0] m_tgt   [64];
  logic        m_mp;
  logic [31:0] m_redir;
  logic [31:0] m_br;
  logic [31:0] m_mpc;

  task automatic m_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
      m_ctr[i]   = 1;
      m_tgt[i]   = '0;
    end
    m_mp = 1'b0; m_redir = '0; m_br = '0; m_mpc = '0;
  endtask

  task automatic m_lookup(input logic [31:0] pc, output logic pt, output logic [31:0] ptg);
    int idx;
    idx = int'(pc[7:2]);
    pt  = m_valid[idx] && (m_tag[idx] == pc[15:8]) && (m_ctr[idx] >= 2);
    ptg = pt ? m_tgt[idx] : pc + 32'd4;
  endtask

  typedef struct {
    logic [31:0] if_pc;
    logic        ex_valid;
    logic        ex_is_branch;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        e_pt;
    logic [31:0] e_ptg;
    logic        e_mp;
    logic [31:0] e_redir;
  } vec_t;

  task automatic m_update(input vec_t v);
    int idx;
    bit upd, hit, mp;
    idx = int'(v.ex_pc[7:2]);
    hit = m_valid[idx] && (m_tag[idx] == v.ex_pc[15:8]);
    upd = v.ex_valid && v.ex_is_branch;
    mp  = upd && ((v.ex_taken != v.ex_pred_taken) ||
                  (v.ex_taken && (v.ex_pred_target != v.ex_target)));
    m_mp = mp;
    if (mp) begin
      m_redir = v.ex_taken ? v.ex_target : v.ex_pc + 32'd4;
      if (m_mpc != 32'hFFFF_FFFF) m_mpc = m_mpc + 1;
    end
    if (upd) begin
      if (m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
      if (hit) begin
        if (v.ex_taken) begin
          m_ctr[idx] = (m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1;
          m_tgt[idx] = v.ex_target;
        end else begin
          m_ctr[idx] = (m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1;
        end
      end else begin
        m_valid[idx] = 1'b1;
        m_tag[idx]   = v.ex_pc[15:8];
        m_ctr[idx]   = v.ex_taken ? 2 : 1;
        m_tgt[idx]   = v.ex_target;
      end
    end
  endtask

  function automatic vec_t mk(input logic [31:0] ipc, input logic vl, input logic br,
                              input logic [31:0] epc, input logic tk, input logic [31:0] tg,
                              input logic ppt, input logic [31:0] pptg,
                              input logic e_pt, input logic [31:0] e_ptg,
                              input logic e_mp, input logic [31:0] e_redir);
    vec_t v;
    v.if_pc = ipc; v.ex_valid = vl; v.ex_is_branch = br; v.ex_pc = epc;
    v.ex_taken = tk; v.ex_target = tg; v.ex_pred_taken = ppt; v.ex_pred_target = pptg;
    v.e_pt = e_pt; v.e_ptg = e_ptg; v.e_mp = e_mp; v.e_redir = e_redir;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    if_pc = v.if_pc; ex_valid = v.ex_valid; ex_is_branch = v.ex_is_branch;
    ex_pc = v.ex_pc; ex_taken = v.ex_taken; ex_target = v.ex_target;
    ex_pred_taken = v.ex_pred_taken; ex_pred_target = v.ex_pred_target;
  endtask

  // One cycle, entered at posedge+1: drive, check lookup, clock, check results.
  task automatic cycle(input vec_t v, input bit use_tab, input string nm);
    logic        pt;
    logic [31:0] ptg;
    drive(v);
    #2;
    m_lookup(v.if_pc, pt, ptg);
    chk({nm, ".pred_taken"},  pred_taken,  use_tab ? 32'(v.e_pt) : 32'(pt));
    chk({nm, ".pred_target"}, pred_target, use_tab ? v.e_ptg : ptg);
    @(posedge clk); #1;
    m_update(v);
    chk({nm, ".mispredict"},  mispredict,  use_tab ? 32'(v.e_mp) : 32'(m_mp));
    chk({nm, ".redirect_pc"}, redirect_pc, use_tab ? v.e_redir : m_redir);
    chk({nm, ".br_count"},    br_count,    m_br);
    chk({nm, ".mp_count"},    mp_count,    m_mpc);
  endtask

  function automatic logic [31:0] rnd_pc();
    case ($urandom_range(0, 5))
      0: return 32'h100;
      1: return 32'h200;
      2: return 32'h104;
      3: return 32'h1_0100;
      default: return $urandom & 32'hFFFF_FFFC;
    endcase
  endfunction

  function automatic logic [31:0] rnd_tgt();
    case ($urandom_range(0, 3))
      0: return 32'h80;
      1: return 32'h200;
      2: return 32'h300;
      default: return $urandom & 32'hFFFF_FFFC;
    endcase
  endfunction

  vec_t vecs[$];

  initial begin
    vec_t        v;
    logic        pt;
    logic [31:0] ptg;

    // idle lookup / directed training of 0x100 (counter path 01->10->01->00->01->10->11->11->10)
    vecs.push_back(mk(32'h100, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h104, 0, 32'h0));
    vecs.push_back(mk(32'h100, 1, 1, 32'h100, 1, 32'h80,  0, 32'h104, 0, 32'h104, 1, 32'h80));
    vecs.push_back(mk(32'h100, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h80,  0, 32'h80));
    vecs.push_back(mk(32'h100, 1, 1, 32'h100, 0, 32'h80,  1, 32'h80,  1, 32'h80,  1, 32'h104));
    vecs.push_back(mk(32'h100, 1, 1, 32'h100, 0, 32'h80,  0, 32'h104, 0, 32'h104, 0, 32'h104));
    vecs.push_back(mk(32'h100, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h104, 0, 32'h104));
    vecs.push_back(mk(32'h100, 1, 1, 32'h100, 1, 32'h80,  0, 32'h104, 0, 32'h104, 1, 32'h80));
    vecs.push_back(mk(32'h100, 1, 1, 32'h100, 1, 32'h80,  0, 32'h104, 0, 32'h104, 1, 32'h80));
    vecs.push_back(mk(32'h100, 1, 1, 32'h100, 1, 32'h80,  1, 32'h80,  1, 32'h80,  0, 32'h80));
    vecs.push_back(mk(32'h100, 1, 1, 32'h100, 1, 32'h80,  1, 32'h80,  1, 32'h80,  0, 32'h80));
    vecs.push_back(mk(32'h100, 1, 1, 32'h100, 0, 32'h80,  0, 32'h104, 1, 32'h80,  0, 32'h80));
    vecs.push_back(mk(32'h100, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h80,  0, 32'h80));
    // taken with wrong predicted target, then alias replacement by 0x200
    vecs.push_back(mk(32'h100, 1, 1, 32'h100, 1, 32'h200, 1, 32'h80,  1, 32'h80,  1, 32'h200));
    vecs.push_back(mk(32'h100, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h200, 0, 32'h200));
    vecs.push_back(mk(32'h100, 1, 1, 32'h200, 1, 32'h300, 0, 32'h204, 1, 32'h200, 1, 32'h300));
    vecs.push_back(mk(32'h100, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h104, 0, 32'h300));
    vecs.push_back(mk(32'h200, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h300, 0, 32'h300));
    // gated updates: not a branch / not valid
    vecs.push_back(mk(32'h200, 1, 0, 32'h200, 1, 32'h999, 0, 32'h0,   1, 32'h300, 0, 32'h300));
    vecs.push_back(mk(32'h200, 0, 1, 32'h200, 1, 32'h999, 0, 32'h0,   1, 32'h300, 0, 32'h300));
    vecs.push_back(mk(32'h200, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h300, 0, 32'h300));

    m_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    chk("reset.mispredict",  mispredict,  32'h0);
    chk("reset.redirect_pc", redirect_pc, 32'h0);
    chk("reset.br_count",    br_count,    32'h0);
    chk("reset.mp_count",    mp_count,    32'h0);

    for (int i = 0; i < vecs.size(); i++)
      cycle(vecs[i], 1'b1, $sformatf("vec%0d", i));
    chk("table.br_count", br_count, 32'd10);
    chk("table.mp_count", mp_count, 32'd6);

    // Reset asserted mid-cycle while an update is pending and mispredict is high.
    v = mk(32'h200, 1, 1, 32'h200, 0, 32'h300, 1, 32'h300, 1, 32'h300, 1, 32'h204);
    cycle(v, 1'b1, "pre_rst");
    drive(v);
    #1 rst = 1'b0;
    #1;
    m_reset();
    chk("rst_mid.mispredict",  mispredict,  32'h0);
    chk("rst_mid.redirect_pc", redirect_pc, 32'h0);
    chk("rst_mid.br_count",    br_count,    32'h0);
    chk("rst_mid.mp_count",    mp_count,    32'h0);
    chk("rst_mid.pred_taken",  pred_taken,  32'h0);
    chk("rst_mid.pred_target", pred_target, 32'h204);
    @(posedge clk); #1;
    chk("rst_hold.br_count",   br_count,    32'h0);
    chk("rst_hold.mispredict", mispredict,  32'h0);
    rst = 1'b1;

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      v.if_pc        = rnd_pc();
      v.ex_valid     = ($urandom_range(0, 3) != 0);
      v.ex_is_branch = ($urandom_range(0, 4) != 0);
      v.ex_pc        = ($urandom_range(0, 1) == 0) ? v.if_pc : rnd_pc();
      v.ex_taken     = $urandom_range(0, 1) == 1;
      v.ex_target    = rnd_tgt();
      m_lookup(v.ex_pc, pt, ptg);
      if ($urandom_range(0, 2) != 0) begin
        v.ex_pred_taken  = pt;
        v.ex_pred_target = ptg;
      end else begin
        v.ex_pred_taken  = $urandom_range(0, 1) == 1;
        v.ex_pred_target = rnd_tgt();
      end
      v.e_pt = 1'b0; v.e_ptg = '0; v.e_mp = 1'b0; v.e_redir = '0;
      cycle(v, 1'b0, $sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
